// File: rtl/pipe_hazard_ctrl.sv
// Freeze/flush sequencer for the 5-stage pipeline.
// Merges memory, branch and data-hazard stalls into stage-register controls.
module pipe_hazard_ctrl #(
  parameter int unsigned BR_FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT     = 255,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             back_freeze,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mem_timeout,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam int unsigned BW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [3:0]    REM_LOAD = 4'(BR_FLUSH_CYCLES - 1);
  localparam logic [BW-1:0] TO_MAX   = BW'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  logic [3:0]      rem_q, rem_d;
  logic [BW-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flev_q, flev_d;
  logic            to_q, to_d;

  logic pc_frz, ifid_frz, ifid_fl, idex_fl, bk_frz;
  logic br_acc;
  logic flushing;

  // A wait that interrupted a flush sequence resumes it once memory frees.
  assign flushing = (state_q == FLUSH) ||
                    (state_q == MEM_WAIT && rem_q != 4'd0);

  always_comb begin
    pc_frz   = 1'b0;
    ifid_frz = 1'b0;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    bk_frz   = 1'b0;
    br_acc   = 1'b0;
    state_d  = state_q;
    rem_d    = rem_q;
    if (mem_busy) begin
      pc_frz   = 1'b1;
      ifid_frz = 1'b1;
      bk_frz   = 1'b1;
      state_d  = MEM_WAIT;
    end else if (flushing) begin
      ifid_frz = 1'b1;
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      rem_d    = rem_q - 4'd1;
      state_d  = (rem_q == 4'd1) ? RUN : FLUSH;
    end else if (branch_taken) begin
      ifid_frz = 1'b1;
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      br_acc   = 1'b1;
      if (BR_FLUSH_CYCLES > 1) begin
        rem_d   = REM_LOAD;
        state_d = FLUSH;
      end else begin
        state_d = RUN;
      end
    end else if (hazard) begin
      pc_frz   = 1'b1;
      ifid_frz = 1'b1;
      idex_fl  = 1'b1;
      state_d  = RUN;
    end else begin
      state_d  = RUN;
    end
  end

  always_comb begin
    busy_d = '0;
    if (mem_busy)
      busy_d = (busy_q == TO_MAX) ? busy_q : busy_q + BW'(1);
    to_d = to_q | (mem_busy && busy_d == TO_MAX);
    stall_d = stall_q;
    if (pc_frz && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
    flev_d = flev_q;
    if (br_acc && flev_q != '1)
      flev_d = flev_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      rem_q   <= '0;
      busy_q  <= '0;
      stall_q <= '0;
      flev_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
      flev_q  <= flev_d;
      to_q    <= to_d;
    end
  end

  assign pc_freeze    = pc_frz   & ~rst;
  assign if_id_freeze = ifid_frz & ~rst;
  assign if_id_flush  = ifid_fl  & ~rst;
  assign id_ex_flush  = idex_fl  & ~rst;
  assign back_freeze  = bk_frz   & ~rst;
  assign stall_cycles = stall_q;
  assign flush_events = flev_q;
  assign mem_timeout  = to_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// BR_FLUSH_CYCLES=2, MEM_TIMEOUT=3.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard, branch_taken, mem_busy;
  logic        pc_freeze, if_id_freeze, if_id_flush;
  logic        id_ex_flush, back_freeze;
  logic [15:0] stall_cycles, flush_events;
  logic        mem_timeout;
  logic [1:0]  state_dbg;
  logic [4:0]  ctrl;

  int checks = 0;
  int failures = 0;

  localparam logic [4:0] C_IDLE = 5'b00000;
  localparam logic [4:0] C_HAZ  = 5'b11010;
  localparam logic [4:0] C_FL   = 5'b01110;
  localparam logic [4:0] C_MEM  = 5'b11001;

  pipe_hazard_ctrl #(
    .BR_FLUSH_CYCLES(2),
    .MEM_TIMEOUT(3),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hazard(hazard),
    .branch_taken(branch_taken),
    .mem_busy(mem_busy),
    .pc_freeze(pc_freeze),
    .if_id_freeze(if_id_freeze),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .back_freeze(back_freeze),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events),
    .mem_timeout(mem_timeout),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_freeze, if_id_freeze, if_id_flush,
                 id_ex_flush, back_freeze};

  task automatic drive(input logic h, input logic b, input logic m);
    @(negedge clk);
    hazard = h;
    branch_taken = b;
    mem_busy = m;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    hazard = 1'b1;
    branch_taken = 1'b0;
    mem_busy = 1'b0;
    #3;
    checks++;
    if (ctrl !== C_IDLE) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_IDLE);
    end
    checks++;
    if (state_dbg !== 2'd0 || stall_cycles !== 16'd0 ||
        flush_events !== 16'd0 || mem_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs got st=%0d sc=%0d fe=%0d to=%b exp 0",
               state_dbg, stall_cycles, flush_events, mem_timeout);
    end
    @(negedge clk);
    hazard = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_hazard;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++;
      if (ctrl !== C_HAZ) begin
        failures++;
        $display("FAIL hazard_ctrl[%0d] got=%b exp=%b", i, ctrl, C_HAZ);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== C_IDLE || stall_cycles !== 16'd3) begin
      failures++;
      $display("FAIL hazard_end got ctrl=%b sc=%0d exp ctrl=%b sc=3",
               ctrl, stall_cycles, C_IDLE);
    end
  endtask

  task automatic test_branch;
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (ctrl !== C_FL || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL branch_c0 got ctrl=%b st=%0d exp ctrl=%b st=0",
               ctrl, state_dbg, C_FL);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== C_FL || state_dbg !== 2'd2 || flush_events !== 16'd1) begin
      failures++;
      $display("FAIL branch_c1 got ctrl=%b st=%0d fe=%0d exp ctrl=%b st=2 fe=1",
               ctrl, state_dbg, flush_events, C_FL);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== C_IDLE || state_dbg !== 2'd0 || stall_cycles !== 16'd3) begin
      failures++;
      $display("FAIL branch_end got ctrl=%b st=%0d sc=%0d exp ctrl=0 st=0 sc=3",
               ctrl, state_dbg, stall_cycles);
    end
  endtask

  task automatic test_mem_in_flush;
    logic [1:0] est;
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      est = (i == 0) ? 2'd2 : 2'd1;
      checks++;
      if (ctrl !== C_MEM || state_dbg !== est) begin
        failures++;
        $display("FAIL memflush_busy[%0d] got ctrl=%b st=%0d exp ctrl=%b st=%0d",
                 i, ctrl, state_dbg, C_MEM, est);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== C_FL || state_dbg !== 2'd1) begin
      failures++;
      $display("FAIL memflush_resume got ctrl=%b st=%0d exp ctrl=%b st=1",
               ctrl, state_dbg, C_FL);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== C_IDLE || state_dbg !== 2'd0 ||
        stall_cycles !== 16'd7 || flush_events !== 16'd2) begin
      failures++;
      $display("FAIL memflush_end got ctrl=%b st=%0d sc=%0d fe=%0d exp 0 0 7 2",
               ctrl, state_dbg, stall_cycles, flush_events);
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_IDLE || state_dbg !== 2'd0 || stall_cycles !== 16'd0 ||
        flush_events !== 16'd0 || mem_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got ctrl=%b st=%0d sc=%0d fe=%0d to=%b exp all 0",
               ctrl, state_dbg, stall_cycles, flush_events, mem_timeout);
    end
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== C_IDLE || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_after got ctrl=%b st=%0d exp 0 0",
               ctrl, state_dbg);
    end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      checks++;
      if (mem_timeout !== (i >= 3)) begin
        failures++;
        $display("FAIL timeout_busy[%0d] got=%b exp=%b",
                 i, mem_timeout, (i >= 3));
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (mem_timeout !== 1'b1 || stall_cycles !== 16'd5) begin
      failures++;
      $display("FAIL timeout_drop got to=%b sc=%0d exp to=1 sc=5",
               mem_timeout, stall_cycles);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (mem_timeout !== 1'b1 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL timeout_sticky got to=%b st=%0d exp to=1 st=0",
               mem_timeout, state_dbg);
    end
  endtask

  task automatic test_branch_hazard;
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (ctrl !== C_FL) begin
      failures++;
      $display("FAIL brhaz_c0 got=%b exp=%b", ctrl, C_FL);
    end
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (ctrl !== C_FL) begin
      failures++;
      $display("FAIL brhaz_c1 got=%b exp=%b", ctrl, C_FL);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== C_IDLE || stall_cycles !== 16'd5 || flush_events !== 16'd1) begin
      failures++;
      $display("FAIL brhaz_end got ctrl=%b sc=%0d fe=%0d exp 0 5 1",
               ctrl, stall_cycles, flush_events);
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (ctrl !== C_MEM) begin
      failures++;
      $display("FAIL b2b_busy got=%b exp=%b", ctrl, C_MEM);
    end
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (ctrl !== C_FL || state_dbg !== 2'd1 || flush_events !== 16'd1) begin
      failures++;
      $display("FAIL b2b_release got ctrl=%b st=%0d fe=%0d exp ctrl=%b st=1 fe=1",
               ctrl, state_dbg, flush_events, C_FL);
    end
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (ctrl !== C_FL || state_dbg !== 2'd2 || flush_events !== 16'd2) begin
      failures++;
      $display("FAIL b2b_flush got ctrl=%b st=%0d fe=%0d exp ctrl=%b st=2 fe=2",
               ctrl, state_dbg, flush_events, C_FL);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== C_IDLE || state_dbg !== 2'd0 || flush_events !== 16'd2) begin
      failures++;
      $display("FAIL b2b_end got ctrl=%b st=%0d fe=%0d exp 0 0 2",
               ctrl, state_dbg, flush_events);
    end
  endtask

  initial begin
    test_reset;
    test_hazard;
    test_branch;
    test_mem_in_flush;
    test_reset_mid;
    test_timeout;
    test_branch_hazard;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
